// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined multiply-accumulate engine:
// mode encodings and the saturation clamp values.
package mac_pkg;

  typedef enum logic [1:0] {
    MODE_MULADD = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_ACC    = 2'b10,
    MODE_CLEAR  = 2'b11
  } mac_mode_t;

  // Limits are returned 64 bits wide; callers keep the low ACC_WIDTH bits.
  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
  } sat_limits_t;

  function automatic sat_limits_t sat_limits(input int width, input bit is_signed);
    sat_limits_t lim;
    logic [63:0] ones;
    ones = '1;
    if (is_signed) begin
      lim.hi = ones >> (65 - width);
      lim.lo = 64'd1 << (width - 1);
    end else begin
      lim.hi = ones >> (64 - width);
      lim.lo = '0;
    end
    return lim;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational ACC_WIDTH adder with overflow detect; clamps or wraps the
// result depending on SATURATE. Operands are already ACC_WIDTH wide.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = 20,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1
) (
  input  logic [ACC_WIDTH-1:0] x,
  input  logic [ACC_WIDTH-1:0] y,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam sat_limits_t LIM = sat_limits(ACC_WIDTH, SIGNED != 0);

  logic [ACC_WIDTH:0] x_ext;
  logic [ACC_WIDTH:0] y_ext;
  logic [ACC_WIDTH:0] full;

  // One guard bit holds the true sum of two ACC_WIDTH operands exactly.
  assign x_ext = {(SIGNED != 0) & x[ACC_WIDTH-1], x};
  assign y_ext = {(SIGNED != 0) & y[ACC_WIDTH-1], y};
  assign full  = x_ext + y_ext;

  generate
    if (SIGNED != 0) begin : g_signed_ovf
      assign overflow = full[ACC_WIDTH] ^ full[ACC_WIDTH-1];
    end else begin : g_unsigned_ovf
      assign overflow = full[ACC_WIDTH];
    end
  endgenerate

  always_comb begin
    sum = full[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && overflow) begin
      // A negative true sum (guard bit set) only occurs for signed operands.
      if ((SIGNED != 0) && full[ACC_WIDTH])
        sum = LIM.lo[ACC_WIDTH-1:0];
      else
        sum = LIM.hi[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mac_accum_pipe.sv
// Three-stage multiply-accumulate pipeline: S1 operand capture, S2 product,
// S3 add/accumulate with optional saturation and a sticky overflow flag.
module mac_accum_pipe
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int SIGNED      = 0,
  parameter int SATURATE    = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  input  logic [ACC_WIDTH-1:0]   c,
  output logic                   out_valid,
  output logic [ACC_WIDTH-1:0]   out,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] acc_count
);

  localparam int PW = 2 * DATA_WIDTH;

  generate
    if (ACC_WIDTH < PW + 1) begin : g_acc_width_check
      $error("mac_accum_pipe: ACC_WIDTH must be at least 2*DATA_WIDTH+1");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 18) begin : g_data_width_check
      $error("mac_accum_pipe: DATA_WIDTH must be in 2..18");
    end
  endgenerate

  logic                   s1_valid_reg;
  mac_mode_t              s1_mode_reg;
  logic [DATA_WIDTH-1:0]  s1_a_reg;
  logic [DATA_WIDTH-1:0]  s1_b_reg;
  logic [ACC_WIDTH-1:0]   s1_c_reg;

  logic                   s2_valid_reg;
  mac_mode_t              s2_mode_reg;
  logic [PW-1:0]          s2_p_reg;
  logic [ACC_WIDTH-1:0]   s2_c_reg;

  logic                   out_valid_reg;
  logic [ACC_WIDTH-1:0]   out_reg, out_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic                   ovf_reg, ovf_next;
  logic [COUNT_WIDTH-1:0] cnt_reg, cnt_next;

  logic [PW-1:0]          a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0]   p_ext, add_x, add_sum;
  logic                   add_ovf;

  // The low PW bits of a PW x PW product of extended operands are the exact
  // signed (or unsigned) product, so one multiplier serves both modes.
  assign a_ext = {{DATA_WIDTH{(SIGNED != 0) & s1_a_reg[DATA_WIDTH-1]}}, s1_a_reg};
  assign b_ext = {{DATA_WIDTH{(SIGNED != 0) & s1_b_reg[DATA_WIDTH-1]}}, s1_b_reg};
  assign prod  = a_ext * b_ext;

  assign p_ext = {{(ACC_WIDTH - PW){(SIGNED != 0) & s2_p_reg[PW-1]}}, s2_p_reg};
  assign add_x = (s2_mode_reg == MODE_ACC) ? acc_reg : s2_c_reg;

  mac_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_sat_add (
    .x        (add_x),
    .y        (p_ext),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    acc_next = acc_reg;
    out_next = out_reg;
    ovf_next = ovf_reg;
    cnt_next = cnt_reg;
    if (s2_valid_reg) begin
      case (s2_mode_reg)
        MODE_MULADD: begin
          out_next = add_sum;
          ovf_next = ovf_reg | add_ovf;
        end
        MODE_LOAD: begin
          acc_next = add_sum;
          out_next = add_sum;
          ovf_next = add_ovf;
          cnt_next = COUNT_WIDTH'(1);
        end
        MODE_ACC: begin
          acc_next = add_sum;
          out_next = add_sum;
          ovf_next = ovf_reg | add_ovf;
          if (cnt_reg != '1)
            cnt_next = cnt_reg + COUNT_WIDTH'(1);
        end
        MODE_CLEAR: begin
          acc_next = '0;
          out_next = '0;
          ovf_next = 1'b0;
          cnt_next = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_mode_reg   <= MODE_MULADD;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_c_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      s2_mode_reg   <= MODE_MULADD;
      s2_p_reg      <= '0;
      s2_c_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      s1_valid_reg  <= in_valid;
      s1_mode_reg   <= mac_mode_t'(mode);
      s1_a_reg      <= a;
      s1_b_reg      <= b;
      s1_c_reg      <= c;
      s2_valid_reg  <= s1_valid_reg;
      s2_mode_reg   <= s1_mode_reg;
      s2_p_reg      <= prod;
      s2_c_reg      <= s1_c_reg;
      out_valid_reg <= s2_valid_reg;
      out_reg       <= out_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign overflow  = ovf_reg;
  assign acc_count = cnt_reg;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Table-driven bench: three engine variants (unsigned/saturating,
// unsigned/wrapping, signed/saturating) share one stimulus stream.
module tb_mac_accum_pipe;

  localparam logic [1:0] M_MULADD = 2'b00;
  localparam logic [1:0] M_LOAD   = 2'b01;
  localparam logic [1:0] M_ACC    = 2'b10;
  localparam logic [1:0] M_CLEAR  = 2'b11;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  mode;
  logic [7:0]  a, b;
  logic [19:0] c;

  logic [2:0]  ov_d;
  logic [2:0]  ovf_d;
  logic [19:0] out_d [3];
  logic [7:0]  cnt_d [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          vld;
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [19:0] c;
    int          sel;
    bit          eov;
    logic [19:0] eout;
    logic [7:0]  ecnt;
    bit          eovf;
  } vec_t;

  vec_t vq[$];

  mac_accum_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(1), .COUNT_WIDTH(8)) u_def (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .c(c),
    .out_valid(ov_d[0]), .out(out_d[0]), .overflow(ovf_d[0]), .acc_count(cnt_d[0]));

  mac_accum_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(0), .COUNT_WIDTH(8)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .c(c),
    .out_valid(ov_d[1]), .out(out_d[1]), .overflow(ovf_d[1]), .acc_count(cnt_d[1]));

  mac_accum_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(1), .COUNT_WIDTH(8)) u_sgn (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .c(c),
    .out_valid(ov_d[2]), .out(out_d[2]), .overflow(ovf_d[2]), .acc_count(cnt_d[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic void push_vec(input bit vld, input logic [1:0] md, input logic [7:0] va,
                                   input logic [7:0] vb, input logic [19:0] vc, input int sel,
                                   input bit eov, input logic [19:0] eout, input logic [7:0] ecnt,
                                   input bit eovf);
    vec_t v;
    v.vld = vld; v.mode = md; v.a = va; v.b = vb; v.c = vc; v.sel = sel;
    v.eov = eov; v.eout = eout; v.ecnt = ecnt; v.eovf = eovf;
    vq.push_back(v);
  endfunction

  task automatic drive(input bit vld, input logic [1:0] md, input logic [7:0] va,
                       input logic [7:0] vb, input logic [19:0] vc);
    in_valid = vld; mode = md; a = va; b = vb; c = vc;
  endtask

  task automatic check_dut(input string tag, input int s, input bit eov, input logic [19:0] eout,
                           input logic [7:0] ecnt, input bit eovf);
    chk({tag, " out_valid"}, 32'(ov_d[s]), 32'(eov));
    chk({tag, " out"}, 32'(out_d[s]), 32'(eout));
    chk({tag, " acc_count"}, 32'(cnt_d[s]), 32'(ecnt));
    chk({tag, " overflow"}, 32'(ovf_d[s]), 32'(eovf));
  endtask

  // Vector k is driven on a falling edge and its result is visible on the
  // falling edge three cycles later; rows are checked there, one per cycle.
  task automatic run_vecs(input string grp, input bit fresh);
    int n;
    n = vq.size();
    for (int k = 0; k < n + 3; k++) begin
      @(negedge clk);
      if (fresh && k > 0 && k < 3)
        chk($sformatf("%s early%0d out_valid", grp, k), 32'(ov_d[vq[0].sel]), 32'd0);
      if (k >= 3) begin
        vec_t v;
        v = vq[k-3];
        check_dut($sformatf("%s row%0d dut%0d", grp, k - 3, v.sel), v.sel, v.eov, v.eout, v.ecnt, v.eovf);
      end
      if (k < n) drive(vq[k].vld, vq[k].mode, vq[k].a, vq[k].b, vq[k].c);
      else drive(1'b0, M_MULADD, 8'd0, 8'd0, 20'd0);
    end
    vq.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, M_MULADD, 8'd0, 8'd0, 20'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_dut($sformatf("reset dut%0d", s), s, 1'b0, 20'd0, 8'd0, 1'b0);

    // Basic MULADD on the default configuration
    push_vec(1, M_MULADD, 8'd3, 8'd4, 20'd5, 0, 1, 20'd17, 8'd0, 0);

    // LOAD + 16 back-to-back ACCs, then one saturating ACC and a CLEAR
    push_vec(1, M_LOAD, 8'd2, 8'd2, 20'd0, 0, 1, 20'd4, 8'd1, 0);
    for (int k = 1; k <= 16; k++)
      push_vec(1, M_ACC, 8'd255, 8'd255, 20'd0, 0, 1, 20'(4 + 65025 * k), 8'(1 + k), 0);
    push_vec(1, M_ACC, 8'd255, 8'd255, 20'd0, 0, 1, 20'd1048575, 8'd18, 1);
    push_vec(1, M_CLEAR, 8'd0, 8'd0, 20'd0, 0, 1, 20'd0, 8'd0, 0);

    // Same stream on the wrapping variant
    push_vec(1, M_LOAD, 8'd2, 8'd2, 20'd0, 1, 1, 20'd4, 8'd1, 0);
    for (int k = 1; k <= 16; k++)
      push_vec(1, M_ACC, 8'd255, 8'd255, 20'd0, 1, 1, 20'(4 + 65025 * k), 8'(1 + k), 0);
    push_vec(1, M_ACC, 8'd255, 8'd255, 20'd0, 1, 1, 20'd56853, 8'd18, 1);
    push_vec(1, M_CLEAR, 8'd0, 8'd0, 20'd0, 1, 1, 20'd0, 8'd0, 0);

    // Signed variant: -3*5-10, (-128)*(-128), then + (-128)*127
    push_vec(1, M_MULADD, 8'hFD, 8'h05, 20'hFFFF6, 2, 1, 20'hFFFE7, 8'd0, 0);
    push_vec(1, M_LOAD, 8'h80, 8'h80, 20'd0, 2, 1, 20'd16384, 8'd1, 0);
    push_vec(1, M_ACC, 8'h80, 8'h7F, 20'd0, 2, 1, 20'd128, 8'd2, 0);

    // Bubbles: out_valid 1,0,0,1 and out held across the gap
    push_vec(1, M_LOAD, 8'd0, 8'd0, 20'd0, 0, 1, 20'd0, 8'd1, 0);
    push_vec(1, M_ACC, 8'd1, 8'd1, 20'd0, 0, 1, 20'd1, 8'd2, 0);
    push_vec(0, M_ACC, 8'd1, 8'd1, 20'd0, 0, 0, 20'd1, 8'd2, 0);
    push_vec(0, M_ACC, 8'd1, 8'd1, 20'd0, 0, 0, 20'd1, 8'd2, 0);
    push_vec(1, M_ACC, 8'd1, 8'd1, 20'd0, 0, 1, 20'd2, 8'd3, 0);
    run_vecs("main", 1'b1);

    // Reset pulsed on the third of three consecutive ACCs
    @(negedge clk); drive(1'b1, M_ACC, 8'd1, 8'd1, 20'd0);
    @(negedge clk); drive(1'b1, M_ACC, 8'd1, 8'd1, 20'd0);
    @(negedge clk); drive(1'b1, M_ACC, 8'd1, 8'd1, 20'd0); reset = 1'b1;
    @(negedge clk); drive(1'b0, M_MULADD, 8'd0, 8'd0, 20'd0); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midreset cyc%0d out_valid", i), 32'(ov_d), 32'd0);
    end
    for (int s = 0; s < 3; s++)
      check_dut($sformatf("midreset dut%0d", s), s, 1'b0, 20'd0, 8'd0, 1'b0);

    // Accumulator must have restarted from zero; then a plain LOAD
    push_vec(1, M_ACC, 8'd1, 8'd1, 20'd0, 0, 1, 20'd1, 8'd1, 0);
    push_vec(1, M_LOAD, 8'd1, 8'd1, 20'd0, 0, 1, 20'd1, 8'd1, 0);
    run_vecs("post", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
